// File: rtl/aes_encipher_block.sv
// Iterative AES encipher datapath: one round per clock, AES-128 or AES-256.
// The round key comes combinationally from an external key memory that is
// addressed by the registered round index.

// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the inverse for x != 0 and maps 0 to 0, as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x126, x127;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x126 = gf_mul(x120, x6);
    x127 = gf_mul(x126, x);
    return gf_mul(x127, x127);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Combinational S-box lookup.
  always_comb begin
    logic [7:0] inv;
    inv      = gf_inv(in_byte);
    out_byte = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  end

endmodule

module aes_encipher_block #(
  parameter int AES_128_ROUNDS = 10,
  parameter int AES_256_ROUNDS = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready,
  output logic         valid
);

  localparam logic [3:0] ROUNDS_128 = 4'(AES_128_ROUNDS);
  localparam logic [3:0] ROUNDS_256 = 4'(AES_256_ROUNDS);

  typedef enum logic [1:0] {IDLE, INIT, MAIN, FINAL} fsm_t;

  fsm_t         fsm;
  logic [127:0] state_reg;
  logic [3:0]   num_rounds;
  logic [3:0]   round_inc;
  logic [127:0] sub_out;
  logic [127:0] shift_out;
  logic [127:0] mix_out;
  logic [127:0] main_out;
  logic [127:0] final_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // SubBytes: sixteen parallel S-boxes over the current state.
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (state_reg[8*i +: 8]),
      .out_byte (sub_out[8*i +: 8])
    );
  end

  // ShiftRows and MixColumns; bytes are column-major with s00 in the top byte.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path can
    // leave it unassigned and infer a latch.
    shift_out = '0;
    mix_out   = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_out[127 - 8*(4*c + r) -: 8] = sub_out[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mix_out[127 - 32*c -: 32] = mix_column(shift_out[127 - 32*c -: 32]);
    end
  end

  assign main_out  = mix_out ^ round_key;
  assign final_out = shift_out ^ round_key;
  assign round_inc = round + 4'd1;

  // Round-sequencing FSM with registered outputs; reset aborts any operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      fsm        <= IDLE;
      state_reg  <= '0;
      num_rounds <= '0;
      round      <= '0;
      new_block  <= '0;
      ready      <= 1'b1;
      valid      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (next) begin
            state_reg  <= block;
            num_rounds <= keylen ? ROUNDS_256 : ROUNDS_128;
            round      <= '0;
            ready      <= 1'b0;
            valid      <= 1'b0;
            fsm        <= INIT;
          end
        end
        INIT: begin
          state_reg <= state_reg ^ round_key;
          round     <= 4'd1;
          fsm       <= MAIN;
        end
        MAIN: begin
          state_reg <= main_out;
          round     <= round_inc;
          if (round_inc == num_rounds) fsm <= FINAL;
        end
        FINAL: begin
          new_block <= final_out;
          ready     <= 1'b1;
          valid     <= 1'b1;
          round     <= '0;
          fsm       <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
